// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and types for the block instruction fetch front end:
// opcode field bounds, the NOP opcode and the pass FSM state encoding.
package instr_fetch_queue_pkg;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_MSB = 4;

    localparam logic [OPC_MSB:OPC_LSB] BLOCK_INSTR_NOP = 5'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pass_state_e;

    function automatic logic is_nop_opc(input logic [OPC_MSB:OPC_LSB] opc);
        return opc == BLOCK_INSTR_NOP;
    endfunction

endpackage

// File: rtl/instr_queue_fifo.sv
// Registered-memory FIFO with a combinational head. Bit 0 of each entry is a
// flag that can be set after the fact on the most recently pushed entry.
module instr_queue_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4,
    localparam int unsigned PW   = $clog2(depth)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [width-1:0] data_i,
    input  logic             pop_i,
    input  logic             mark_last_i,
    output logic [width-1:0] head_o,
    output logic [PW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      cnt_q;
    logic [PW-1:0]    tail_idx;
    logic             mark_ok;

    assign tail_idx = wr_q - PW'(1);
    // The tail may only be flagged while it is still queued after this cycle.
    assign mark_ok  = mark_last_i &&
                      ((cnt_q > (PW+1)'(1)) || (cnt_q != '0 && !pop_i));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
        if (mark_ok) mem_q[tail_idx][0] <= 1'b1;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == (PW+1)'(depth);
    assign empty_o = cnt_q == '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// Streams block instruction words from a synchronous RAM into a small queue,
// with credit-limited prefetch, NOP filtering and per-sample pass control.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned n_blocks     = 256,
    parameter int unsigned instr_width  = 32,
    parameter int unsigned depth        = 4,
    parameter int unsigned read_latency = 1,
    parameter int unsigned per_sample   = 1,
    localparam int unsigned AW          = $clog2(n_blocks)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sample_tick,
    input  logic [AW-1:0]          n_blocks_running,
    input  logic [AW-1:0]          last_block,
    output logic [AW-1:0]          instr_read_addr,
    input  logic [instr_width-1:0] instr_read_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [instr_width-1:0] out_instr,
    output logic [AW-1:0]          out_block,
    output logic                   out_last,
    output logic                   pass_done,
    output logic                   overrun,
    output logic                   busy
);

    localparam int unsigned QW = $clog2(depth) + 1;
    localparam int unsigned CW = $clog2(depth + read_latency + 1);
    localparam int unsigned EW = instr_width + AW + 1;

    pass_state_e state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          overrun_q, overrun_d;
    logic          aborted_q, aborted_d;

    logic [read_latency-1:0] pv_q;
    logic [read_latency-1:0] plast_q;
    logic [AW-1:0]           pblk_q [read_latency];

    logic [CW-1:0] inflight;
    logic [CW-1:0] credit;
    logic          run_ok;
    logic          issue;
    logic          addr_last;
    logic          ret_valid;
    logic          ret_last;
    logic          ret_nop;

    logic          q_push, q_pop, q_mark, q_full, q_empty;
    logic [EW-1:0] q_head;
    logic [QW-1:0] q_count;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < read_latency; i++) begin
            inflight = inflight + CW'(pv_q[i]);
        end
    end

    assign credit    = CW'(q_count) + inflight;
    assign run_ok    = n_blocks_running != '0;
    assign addr_last = ptr_q == last_block;
    assign issue     = enable && run_ok && (state_q == RUN) && (credit < CW'(depth));

    assign ret_valid = pv_q[read_latency-1];
    assign ret_last  = plast_q[read_latency-1];
    assign ret_nop   = is_nop_opc(instr_read_val[OPC_MSB:OPC_LSB]);
    assign q_push    = ret_valid && !ret_nop;
    assign q_mark    = ret_valid && ret_nop && ret_last;
    assign q_pop     = !q_empty && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q    <= '0;
            plast_q <= '0;
        end else begin
            pv_q[0]    <= issue;
            plast_q[0] <= issue && addr_last;
            for (int unsigned i = 1; i < read_latency; i++) begin
                pv_q[i]    <= pv_q[i-1];
                plast_q[i] <= plast_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pblk_q[0] <= ptr_q;
        for (int unsigned i = 1; i < read_latency; i++) begin
            pblk_q[i] <= pblk_q[i-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        overrun_d = overrun_q;
        aborted_d = aborted_q;
        pass_done = 1'b0;
        if (issue) ptr_d = addr_last ? '0 : ptr_q + AW'(1);
        if (per_sample != 0) begin
            case (state_q)
                IDLE: begin
                    if (sample_tick && run_ok) begin
                        state_d   = RUN;
                        ptr_d     = '0;
                        aborted_d = 1'b0;
                    end
                end
                RUN: begin
                    if (sample_tick) overrun_d = 1'b1;
                    if (!run_ok) begin
                        state_d   = DRAIN;
                        aborted_d = 1'b1;
                    end else if (issue && addr_last) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (sample_tick) overrun_d = 1'b1;
                    if (inflight == '0) begin
                        state_d   = IDLE;
                        pass_done = !aborted_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            // Free-running: a pass ends whenever its last_block read returns.
            pass_done = ret_valid && ret_last;
            case (state_q)
                IDLE:    if (run_ok) state_d = RUN;
                RUN:     if (!run_ok) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            overrun_q <= overrun_d;
            aborted_q <= aborted_d;
        end
    end

    instr_queue_fifo #(
        .width(EW),
        .depth(depth)
    ) u_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .push_i     (q_push),
        .data_i     ({instr_read_val, pblk_q[read_latency-1], ret_last}),
        .pop_i      (q_pop),
        .mark_last_i(q_mark),
        .head_o     (q_head),
        .count_o    (q_count),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(q_full && q_push && !q_pop));

    assign instr_read_addr = ptr_q;
    assign out_valid       = !q_empty;
    assign out_instr       = q_empty ? '0 : q_head[EW-1:AW+1];
    assign out_block       = q_empty ? '0 : q_head[AW:1];
    assign out_last        = !q_empty && q_head[0];
    assign overrun         = overrun_q;
    assign busy            = (state_q != IDLE) || !q_empty;

endmodule
